// File: rtl/dma_loader_pkg.sv
// Shared types for the expansion-port DMA loader: FSM state encoding and
// the C64 bus read/write strobe levels.
package dma_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_FETCH   = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_XFER    = 3'd4,
        ST_FINISH  = 3'd5
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/dma_loader_phi2_edge.sv
// Registered edge detector for a clk-synchronous phi2; also usable by the IEC block.
module phi2_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic phi2,
    output logic rise,
    output logic fall
);

    logic phi2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) phi2_q <= 1'b0;
        else          phi2_q <= phi2;
    end

    assign rise = phi2 & ~phi2_q;
    assign fall = ~phi2 & phi2_q;

endmodule

// File: rtl/dma_loader.sv
// Expansion-port DMA engine: copies ROM bytes into C64 memory, or compares
// C64 memory against ROM, one byte per stolen phi2 cycle.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for start
// REQ      | dma asserted, waiting for a phi2 fall with ba=1
// FETCH    | rom_a driven with the source pointer for one clk
// WAIT_HI  | ROM byte captured, waiting for a phi2 rise with ba=1
// XFER     | bus cycle driven during phi2 high, resolved at the fall
// FINISH   | dma released, done pulsed, back to IDLE
module dma_loader
    import dma_loader_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int SRC_AW = 13,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              phi2,
    input  logic              ba,
    input  logic              start,
    input  logic              abort,
    input  logic              verify,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [SRC_AW-1:0] src_base,
    input  logic [LEN_W-1:0]  length,
    output logic [SRC_AW-1:0] rom_a,
    input  logic [7:0]        rom_d,
    input  logic [7:0]        bus_d,
    output logic              dma,
    output logic [ADDR_W-1:0] a_o,
    output logic [7:0]        d_o,
    output logic              rw,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_addr
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [SRC_AW-1:0] SRC_ONE  = SRC_AW'(1);
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

    logic              phi2_rise;
    logic              phi2_fall;
    state_t            state;
    logic [ADDR_W-1:0] dst;
    logic [SRC_AW-1:0] src;
    logic [LEN_W-1:0]  count;
    logic              mode_verify;
    logic [7:0]        data;
    logic              cap_pend;

    phi2_edge u_phi2_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .phi2    (phi2),
        .rise    (phi2_rise),
        .fall    (phi2_fall)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            dst         <= '0;
            src         <= '0;
            count       <= '0;
            mode_verify <= 1'b0;
            data        <= '0;
            cap_pend    <= 1'b0;
            rom_a       <= '0;
            dma         <= 1'b0;
            a_o         <= '0;
            d_o         <= '0;
            rw          <= RW_READ;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_addr    <= '0;
        end else begin
            done <= 1'b0;
            // abort outranks everything, including a coincident phi2 fall in XFER
            if (abort && state != ST_IDLE && state != ST_FINISH) begin
                state <= ST_FINISH;
                error <= 1'b1;
                dma   <= 1'b0;
                rw    <= RW_READ;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            dst         <= dst_addr;
                            src         <= src_base;
                            count       <= length;
                            mode_verify <= verify;
                            error       <= 1'b0;
                            busy        <= 1'b1;
                            if (length == '0) begin
                                state <= ST_FINISH;
                            end else begin
                                state <= ST_REQ;
                                dma   <= 1'b1;
                            end
                        end
                    end
                    ST_REQ: begin
                        if (phi2_fall && ba) begin
                            state <= ST_FETCH;
                            rom_a <= src;
                        end
                    end
                    ST_FETCH: begin
                        cap_pend <= 1'b1;
                        state    <= ST_WAIT_HI;
                    end
                    ST_WAIT_HI: begin
                        // ROM data lands one clk after the address has been presented
                        if (cap_pend) begin
                            data     <= rom_d;
                            cap_pend <= 1'b0;
                        end
                        if (phi2_rise && ba) begin
                            state <= ST_XFER;
                            a_o   <= dst;
                            d_o   <= cap_pend ? rom_d : data;
                            rw    <= mode_verify ? RW_READ : RW_WRITE;
                        end
                    end
                    ST_XFER: begin
                        if (phi2_fall) begin
                            rw <= RW_READ;
                            if (mode_verify && bus_d != data) begin
                                error    <= 1'b1;
                                err_addr <= dst;
                                state    <= ST_FINISH;
                                dma      <= 1'b0;
                            end else begin
                                count <= count - LEN_ONE;
                                dst   <= dst + ADDR_ONE;
                                src   <= src + SRC_ONE;
                                if (count == LEN_ONE) begin
                                    state <= ST_FINISH;
                                    dma   <= 1'b0;
                                end else begin
                                    state <= ST_FETCH;
                                    rom_a <= src + SRC_ONE;
                                end
                            end
                        end
                    end
                    ST_FINISH: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dma_loader.sv
// Bench for dma_loader: phi2 = clk/8, registered ROM model, C64 memory model,
// expected bus writes / verify outcome derived from ROM and memory contents.
module tb_dma_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  ph_cnt = 3'd0;
    logic        phi2;
    logic        ba = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        verify = 1'b0;
    logic [15:0] dst_addr = '0;
    logic [12:0] src_base = '0;
    logic [15:0] length = '0;
    logic [12:0] rom_a;
    logic [7:0]  rom_d = '0;
    logic [7:0]  bus_d;
    logic        dma;
    logic [15:0] a_o;
    logic [7:0]  d_o;
    logic        rw;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] err_addr;

    logic [7:0]  rom [0:8191];
    logic [7:0]  mem [0:65535];
    logic        corrupt_en = 1'b0;
    logic [15:0] corrupt_addr = '0;

    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          unstable = 0;
    logic [15:0] wq_a[$];
    logic [7:0]  wq_d[$];
    logic [15:0] s_a;
    logic [7:0]  s_d;
    logic        s_rw;
    logic [15:0] exp_err_addr = '0;

    dma_loader dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .phi2     (phi2),
        .ba       (ba),
        .start    (start),
        .abort    (abort),
        .verify   (verify),
        .dst_addr (dst_addr),
        .src_base (src_base),
        .length   (length),
        .rom_a    (rom_a),
        .rom_d    (rom_d),
        .bus_d    (bus_d),
        .dma      (dma),
        .a_o      (a_o),
        .d_o      (d_o),
        .rw       (rw),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_addr (err_addr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ph_cnt <= ph_cnt + 3'd1;
    assign phi2 = ph_cnt[2];
    always @(posedge clk) rom_d <= rom[rom_a];
    assign bus_d = (corrupt_en && a_o == corrupt_addr) ? ~mem[a_o] : mem[a_o];

    // the core latches a write at the phi2 fall; ph_cnt 7 is the last high clk
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (ph_cnt == 3'd5) begin
            s_a  = a_o;
            s_d  = d_o;
            s_rw = rw;
        end
        if (ph_cnt == 3'd7 && dma && !rw) begin
            wq_a.push_back(a_o);
            wq_d.push_back(d_o);
            mem[a_o] = d_o;
            if (a_o !== s_a || d_o !== s_d || rw !== s_rw) unstable++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic run_xfer(input string tag, input logic vmode, input logic [15:0] dst,
                            input logic [12:0] src, input logic [15:0] len,
                            input int stall_at, input int corrupt_idx, input bit poke);
        logic [15:0] ea[$];
        logic [7:0]  ed[$];
        logic        exp_err;
        logic [15:0] a;
        logic [12:0] s;
        int          cyc;
        bit          stalled;
        int          stall_left;
        int          wr_at_stall;
        int          dma_drop;
        exp_err = 1'b0;
        stalled = 1'b0;
        stall_left = 0;
        wr_at_stall = 0;
        dma_drop = 0;
        corrupt_en = (corrupt_idx >= 0);
        corrupt_addr = dst + 16'(corrupt_idx);
        for (int i = 0; i < int'(len); i++) begin
            a = dst + 16'(i);
            s = src + 13'(i);
            if (vmode) begin
                if (!exp_err && ((corrupt_en && a == corrupt_addr) || mem[a] != rom[s])) begin
                    exp_err = 1'b1;
                    exp_err_addr = a;
                end
            end else begin
                ea.push_back(a);
                ed.push_back(rom[s]);
            end
        end
        wq_a.delete();
        wq_d.delete();
        done_cnt = 0;
        @(negedge clk);
        verify = vmode; dst_addr = dst; src_base = src; length = len; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (done_cnt == 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 12) begin
                start = 1'b1; dst_addr = ~dst; src_base = ~src; length = len + 16'd3; verify = ~vmode;
            end
            if (poke && cyc == 13) start = 1'b0;
            if (!stalled && stall_at >= 0 && wq_a.size() == stall_at && ph_cnt == 3'd2) begin
                ba = 1'b0;
                stalled = 1'b1;
                stall_left = 320;
                wr_at_stall = wq_a.size();
            end else if (stall_left > 0) begin
                stall_left--;
                if (!dma) dma_drop++;
                if (stall_left == 0) begin
                    ba = 1'b1;
                    check({tag, " stall_no_write"}, wq_a.size(), wr_at_stall);
                    check({tag, " stall_dma_held"}, dma_drop, 0);
                end
            end
        end
        start = 1'b0;
        ba = 1'b1;
        check({tag, " done_in_time"}, cyc < 3000, 1);
        repeat (24) @(negedge clk);
        corrupt_en = 1'b0;
        check({tag, " done_count"}, done_cnt, 1);
        check({tag, " busy_after"}, busy, 0);
        check({tag, " dma_after"}, dma, 0);
        check({tag, " rw_after"}, rw, 1);
        check({tag, " error"}, error, exp_err);
        check({tag, " err_addr"}, err_addr, exp_err_addr);
        check({tag, " write_count"}, wq_a.size(), ea.size());
        for (int i = 0; i < ea.size() && i < wq_a.size(); i++) begin
            check($sformatf("%s wr%0d_addr", tag, i), wq_a[i], ea[i]);
            check($sformatf("%s wr%0d_data", tag, i), wq_d[i], ed[i]);
        end
    endtask

    initial begin
        int          cyc;
        logic [15:0] rd;
        logic [12:0] rs;
        logic [15:0] rl;
        int          st;
        int          ci;
        for (int i = 0; i < 8192; i++) rom[i] = 8'($urandom);
        rom[0] = 8'hA0; rom[1] = 8'hA1; rom[2] = 8'hA2; rom[3] = 8'hA3;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        repeat (3) @(negedge clk);
        check("rst dma", dma, 0);
        check("rst rw", rw, 1);
        check("rst a_o", a_o, 0);
        check("rst d_o", d_o, 0);
        check("rst rom_a", rom_a, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst error", error, 0);
        check("rst err_addr", err_addr, 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        run_xfer("write4", 1'b0, 16'h8000, 13'h0000, 16'd4, -1, -1, 1'b0);

        done_cnt = 0;
        @(negedge clk);
        verify = 1'b0; length = 16'd0; dst_addr = 16'h1234; start = 1'b1;
        @(posedge clk); #1;
        check("len0 busy_rise", busy, 1);
        check("len0 done_early", done, 0);
        check("len0 dma0", dma, 0);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check("len0 done_pulse", done, 1);
        check("len0 busy_fall", busy, 0);
        check("len0 dma1", dma, 0);
        @(posedge clk); #1;
        check("len0 done_single", done, 0);
        check("len0 dma2", dma, 0);

        run_xfer("stall", 1'b0, 16'h4000, 13'h0100, 16'd4, 2, -1, 1'b0);
        run_xfer("wrap", 1'b0, 16'hFFFE, 13'h1FFE, 16'd4, -1, -1, 1'b0);
        run_xfer("vfy_mis", 1'b1, 16'h8000, 13'h0000, 16'd4, -1, 2, 1'b0);
        check("vfy_mis last_addr", a_o, 16'h8002);

        done_cnt = 0;
        wq_a.delete();
        @(negedge clk);
        verify = 1'b0; dst_addr = 16'h9000; src_base = 13'h1ABC; length = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (rom_a !== 13'h1ABC && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("abort reach_fetch", cyc < 200, 1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort error_next", error, 1);
        check("abort dma_next", dma, 0);
        repeat (8) @(negedge clk);
        check("abort done_count", done_cnt, 1);
        check("abort err_addr_kept", err_addr, exp_err_addr);
        check("abort no_write", wq_a.size(), 0);
        check("abort busy", busy, 0);

        done_cnt = 0;
        @(negedge clk);
        verify = 1'b0; dst_addr = 16'hA000; src_base = 13'h0020; length = 16'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(dma && rw == 1'b0 && ph_cnt == 3'd5) && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("rstx reach_xfer", cyc < 400, 1);
        reset_n = 1'b0;
        #1;
        check("rstx dma", dma, 0);
        check("rstx rw", rw, 1);
        check("rstx a_o", a_o, 0);
        check("rstx d_o", d_o, 0);
        check("rstx rom_a", rom_a, 0);
        check("rstx busy", busy, 0);
        check("rstx error", error, 0);
        check("rstx err_addr", err_addr, 0);
        repeat (16) @(negedge clk);
        check("rstx no_done", done_cnt, 0);
        reset_n = 1'b1;
        exp_err_addr = '0;
        repeat (3) @(negedge clk);

        for (int k = 0; k < 5; k++) begin
            rd = 16'($urandom);
            rs = 13'($urandom);
            rl = 16'($urandom_range(1, 5));
            st = ($urandom_range(0, 1) == 1) ? $urandom_range(0, int'(rl) - 1) : -1;
            run_xfer($sformatf("rnd%0d_wr", k), 1'b0, rd, rs, rl, st, -1,
                     (rl >= 16'd3) && ($urandom_range(0, 1) == 1));
            ci = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, int'(rl) - 1);
            st = ($urandom_range(0, 1) == 1) ? 0 : -1;
            run_xfer($sformatf("rnd%0d_vf", k), 1'b1, rd, rs, rl, st, ci, 1'b0);
        end

        check("bus_stable_high_phase", unstable, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dma_loader.md
# dma_loader

Synthesizable expansion-port DMA engine for the C64 core that copies a block of bytes from an on-board synchronous ROM into C64 memory, or verifies C64 memory against that ROM, by stealing phi2 bus cycles through the `DMA`/`BA` handshake. It sits between a cartridge/boot ROM and the core's `Ai`/`Di`/`DMA`/`RW` expansion inputs. It replaces ad-hoc bench-side image loading with a parametrised block usable in both simulation and hardware, and reports completion and errors on a status pulse.

## Interface
Parameters:
- `ADDR_W`, 16, C64 bus address width
- `SRC_AW`, 13, source ROM address width
- `LEN_W`, 16, transfer length counter width

Ports:
- `clk`  in  1  dot clock; all logic on rising edge
- `reset_n`  in  1  reset, asynchronous, active-low
- `phi2`  in  1  core phi2, synchronous to `clk` (no synchronizer)
- `ba`  in  1  bus available from core; 1 = cycle may be stolen
- `start`  in  1  one-clk request; ignored unless idle
- `abort`  in  1  level; terminates any transfer
- `verify`  in  1  mode, sampled at `start`: 0 = write, 1 = compare
- `dst_addr`  in  ADDR_W  first C64 address, sampled at `start`
- `src_base`  in  SRC_AW  first ROM address, sampled at `start`
- `length`  in  LEN_W  byte count, sampled at `start`
- `rom_a`  out  SRC_AW  ROM address
- `rom_d`  in  8  ROM data, valid 1 clk after `rom_a`
- `bus_d`  in  8  C64 data bus readback (verify mode)
- `dma`  out  1  DMA request to core
- `a_o`  out  ADDR_W  C64 address
- `d_o`  out  8  write data
- `rw`  out  1  1 = read, 0 = write
- `busy`  out  1  transfer in progress
- `done`  out  1  one-clk completion pulse
- `error`  out  1  sticky verify-mismatch/abort flag, cleared by next accepted `start`
- `err_addr`  out  ADDR_W  address of first mismatch

## Operation
- States: IDLE, REQ, FETCH, WAIT_HI, XFER, FINISH.
- IDLE: `start` latches inputs and clears `error`. `length==0` goes directly to FINISH without asserting `dma`. Otherwise go to REQ.
- REQ: `dma`=1. Wait for a phi2 falling edge with `ba`=1, then go to FETCH.
- FETCH: drive `rom_a`=src pointer for one clk, capture `rom_d`, then go to WAIT_HI.
- WAIT_HI: wait for a phi2 rising edge. If `ba`=0 at that edge, stall (a VIC badline is stealing the bus): stay in WAIT_HI, keep `dma`=1 and the data held. If `ba`=1, go to XFER.
- XFER: drive `a_o`/`d_o`. `rw`=0 in write mode and `rw`=1 in verify mode.
  - At the phi2 falling edge, verify mode compares `bus_d` with the captured byte. On mismatch: set `error`, latch `err_addr`, go to FINISH.
  - Otherwise decrement the count and increment both pointers. If the count reaches 0, go to FINISH; else go to FETCH.
- FINISH: `dma`=0, `rw`=1, pulse `done` for one clk, then go to IDLE.
- Pointer arithmetic is modulo 2^width: `dst` $FFFF→$0000 and `src` wrap silently; the transfer continues.
- `abort` in any non-IDLE state: go to FINISH next clk with `error`=1 (`err_addr` unchanged). If `abort` and a phi2 fall coincide in XFER, abort wins and the count is not decremented.
- `start` while busy is ignored.

## Timing
- Reset values: `dma`=0, `rw`=1, `a_o`=0, `d_o`=0, `rom_a`=0, `busy`=0, `done`=0, `error`=0, `err_addr`=0, state IDLE.
- Edge detect uses a registered `phi2_q`: rise = `phi2 & ~phi2_q`, fall = `~phi2 & phi2_q`.
- `busy` rises the clk after `start` is accepted and falls together with the `done` pulse.
- Exactly one byte moves per phi2 cycle with `ba`=1. Minimum transfer time is N phi2 cycles plus up to 1 phi2 cycle for REQ.
- `a_o`, `d_o` and `rw` are stable for the whole phi2-high phase of XFER.
- Reset mid-transfer drops `dma` asynchronously; no `done` pulse is produced.

## Structure
- Package `dma_loader_pkg`: state enum, `RW_READ`/`RW_WRITE` constants.
- One sub-module: `phi2_edge` (registered edge detector), reusable by the IEC block.
- No RAM inside; the ROM is external.

## Test plan
- Write 4 bytes {$A0,$A1,$A2,$A3} from `src_base`=0 to `dst_addr`=$8000 with `ba`=1 → 4 XFER cycles at $8000–$8003 with `rw`=0, then `done` pulse and `dma`=0.
- `length`=0 → `done` one clk after FINISH entry, `dma` never asserted.
- `ba` low for 40 phi2 cycles mid-transfer → no write during the stall, `dma` held, data resumes unchanged, total 4 writes.
- `dst_addr`=$FFFE, `length`=4 → writes at $FFFE, $FFFF, $0000, $0001.
- Verify mode with `bus_d` mismatch on the 3rd byte at $8002 → `error`=1, `err_addr`=$8002, `done` pulsed, no further cycles.
- `abort` asserted during WAIT_HI, and separately `reset_n` low mid-XFER → abort yields `error` and `done`; reset yields all outputs at reset values immediately with no `done`.
